parking_meter_ctrl: RTL

//   Parking-meter time core, downstream of the per-button synchroniser/single-pulse stage.

---
 rtl/parking_meter_ctrl.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/parking_meter_ctrl.sv
// Parking-meter time core: button-driven load/add of seconds remaining, 1 Hz countdown
// from an internal divider, display blink pattern and expiry flag.
// Optional feature macro PMC_BCD_OUT_EN adds a sequential double-dabble BCD view of
// time_left (bcd_digits/bcd_valid). With the macro undefined, no BCD logic or ports exist.
`timescale 1ns/1ps

module parking_meter_ctrl #(
    parameter int unsigned CLK_FREQ_HZ = 100_000_000,
    parameter int unsigned MAX_TIME    = 9999,
    parameter int unsigned ADD_A       = 60,
    parameter int unsigned ADD_B       = 120,
    parameter int unsigned PRESET_A    = 15,
    parameter int unsigned PRESET_B    = 150,
    parameter int unsigned LOW_THRESH  = 180
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_add_a,
    input  logic        btn_add_b,
    input  logic        btn_set_a,
    input  logic        btn_set_b,
    output logic [13:0] time_left,
    output logic        expired,
    output logic        disp_en,
`ifdef PMC_BCD_OUT_EN
    output logic [15:0] bcd_digits,
    output logic        bcd_valid,
`endif
    output logic        sec_tick
);

    localparam int unsigned HalfCnt = (CLK_FREQ_HZ / 2 > 0) ? CLK_FREQ_HZ / 2 : 1;
    localparam int unsigned DivW    = (HalfCnt > 1) ? $clog2(HalfCnt) : 1;

    localparam logic [DivW-1:0] DivLast   = DivW'(HalfCnt - 1);
    localparam logic [14:0]     MaxTime15 = 15'(MAX_TIME);
    localparam logic [14:0]     AddA15    = 15'(ADD_A);
    localparam logic [14:0]     AddB15    = 15'(ADD_B);
    localparam logic [13:0]     PresetA   = 14'(PRESET_A);
    localparam logic [13:0]     PresetB   = 14'(PRESET_B);
    localparam logic [13:0]     LowThresh = 14'(LOW_THRESH);

    typedef enum logic [1:0] {StExpired, StLow, StNormal} state_e;

    logic [13:0]     time_q, time_d;
    logic [DivW-1:0] div_q, div_d;
    logic            half_q, half_d;
    logic            expired_q, expired_d;
    logic            disp_en_q, disp_en_d;
    logic            sec_tick_q, sec_tick_d;
    logic            wrap, tick, restart;
    logic [14:0]     sum;
    state_e          state_d;

    // Next-state: button priority set_b > set_a > add_b > add_a > countdown decrement.
    always_comb begin
        wrap    = (div_q == DivLast);
        tick    = wrap & half_q;
        div_d   = wrap ? '0 : div_q + DivW'(1);
        half_d  = wrap ? ~half_q : half_q;
        time_d  = time_q;
        restart = 1'b0;
        sum     = '0;
        if (btn_set_b) begin
            time_d  = PresetB;
            restart = 1'b1;
        end else if (btn_set_a) begin
            time_d  = PresetA;
            restart = 1'b1;
        end else if (btn_add_b || btn_add_a) begin
            // 15-bit sum so saturation sees the true overflow
            sum     = {1'b0, time_q} + (btn_add_b ? AddB15 : AddA15);
            time_d  = (sum > MaxTime15) ? MaxTime15[13:0] : sum[13:0];
            restart = (time_q == '0);
        end else if (tick && time_q != '0) begin
            time_d = time_q - 14'd1;
        end
        // A fresh load starts a whole new second
        if (restart) begin
            div_d  = '0;
            half_d = 1'b0;
        end
        if (time_d == '0) begin
            state_d = StExpired;
        end else if (time_d < LowThresh) begin
            state_d = StLow;
        end else begin
            state_d = StNormal;
        end
        // Outputs are registered alongside time_left so they track the registered state
        unique case (state_d)
            StNormal: disp_en_d = 1'b1;
            default:  disp_en_d = ~half_d;
        endcase
        expired_d  = (time_d == '0);
        sec_tick_d = tick;
    end

    // Core state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            time_q     <= '0;
            div_q      <= '0;
            half_q     <= 1'b0;
            expired_q  <= 1'b1;
            disp_en_q  <= 1'b0;
            sec_tick_q <= 1'b0;
        end else begin
            time_q     <= time_d;
            div_q      <= div_d;
            half_q     <= half_d;
            expired_q  <= expired_d;
            disp_en_q  <= disp_en_d;
            sec_tick_q <= sec_tick_d;
        end
    end

    assign time_left = time_q;
    assign expired   = expired_q;
    assign disp_en   = disp_en_q;
    assign sec_tick  = sec_tick_q;

`ifdef PMC_BCD_OUT_EN
    logic [13:0] bcd_bin_q, bcd_bin_d;
    logic [15:0] bcd_acc_q, bcd_acc_d, bcd_adj, bcd_shift;
    logic [3:0]  bcd_cnt_q, bcd_cnt_d;
    logic        bcd_busy_q, bcd_busy_d;
    logic [15:0] bcd_digits_q, bcd_digits_d;
    logic        bcd_valid_q, bcd_valid_d;

    // Double-dabble: one add-3/shift step per clk, restarted by any time_left change
    always_comb begin
        bcd_adj = bcd_acc_q;
        for (int i = 0; i < 4; i++) begin
            if (bcd_acc_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_acc_q[4*i +: 4] + 4'd3;
            end
        end
        bcd_shift    = {bcd_adj[14:0], bcd_bin_q[13]};
        bcd_bin_d    = bcd_bin_q;
        bcd_acc_d    = bcd_acc_q;
        bcd_cnt_d    = bcd_cnt_q;
        bcd_busy_d   = bcd_busy_q;
        bcd_digits_d = bcd_digits_q;
        bcd_valid_d  = bcd_valid_q;
        if (time_d != time_q) begin
            bcd_bin_d   = time_d;
            bcd_acc_d   = '0;
            bcd_cnt_d   = '0;
            bcd_busy_d  = 1'b1;
            bcd_valid_d = 1'b0;
        end else if (bcd_busy_q) begin
            bcd_bin_d = {bcd_bin_q[12:0], 1'b0};
            bcd_acc_d = bcd_shift;
            bcd_cnt_d = bcd_cnt_q + 4'd1;
            if (bcd_cnt_q == 4'd13) begin
                bcd_busy_d   = 1'b0;
                bcd_digits_d = bcd_shift;
                bcd_valid_d  = 1'b1;
            end
        end
    end

    // Converter state; digits only update when a conversion completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_bin_q    <= '0;
            bcd_acc_q    <= '0;
            bcd_cnt_q    <= '0;
            bcd_busy_q   <= 1'b0;
            bcd_digits_q <= '0;
            bcd_valid_q  <= 1'b1;
        end else begin
            bcd_bin_q    <= bcd_bin_d;
            bcd_acc_q    <= bcd_acc_d;
            bcd_cnt_q    <= bcd_cnt_d;
            bcd_busy_q   <= bcd_busy_d;
            bcd_digits_q <= bcd_digits_d;
            bcd_valid_q  <= bcd_valid_d;
        end
    end

    assign bcd_digits = bcd_digits_q;
    assign bcd_valid  = bcd_valid_q;
`endif

endmodule
